aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Sequences the AES-128 round datapath for one 128-bit block at a time.
- Takes the committed block (`inputData`), key (`keyWord`) and control bits (`enable`, `encrypt`) from `ahb_receiver`.
- Owns the block-state and working-key registers. It drives the external combinational round function and key-schedule step, one round per clock.
- Returns `result` plus a valid/busy handshake, which `ahb_receiver` uses for `HREADYOUT` stalls on result reads.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds (AES-128); the round counter is 4 bits.
- KEY_W, 128, key, block and state width in bits.

Ports:
- HCLK  in  1  system clock, all logic on rising edge
- HRESET  in  1  synchronous reset, active-high
- enable  in  1  level; when low, new blocks are not accepted
- encrypt  in  1  1=encrypt, 0=decrypt; sampled at block acceptance
- data_valid  in  1  one-cycle pulse: `inputData` committed (addr 401 write)
- inputData  in  128  plaintext or ciphertext block
- key_valid  in  1  one-cycle pulse: `keyWord` committed (addr 402 write)
- keyWord  in  128  AES-128 cipher key
- rnd_state  out  128  current state to round function
- rnd_key  out  128  round key to round function
- rnd_final  out  1  1 = final round (omit MixColumns / InvMixColumns)
- rnd_inverse  out  1  1 = inverse round
- rnd_out  in  128  combinational round-function result
- ks_key  out  128  key into key-schedule step
- ks_rcon_idx  out  4  round index 1..10 for the RCON lookup
- ks_inverse  out  1  1 = inverse key step
- ks_next  in  128  combinational key-schedule result
- result  out  128  last completed output block
- result_valid  out  1  high from completion until the next block is accepted
- busy  out  1  high in KEYEXP, RUN, or while a pending item exists

Behaviour:
- Reset: all outputs and registers are 0, FSM is IDLE, pending flags are cleared. Reset mid-operation aborts the block; no result is produced.
- FSM states: IDLE, KEYEXP, READY, RUN.
- IDLE, on key_valid → KEYEXP: K0 ← `keyWord`, wk ← `keyWord`, cnt ← 1.
- KEYEXP:
  - Forward steps: `ks_key`=wk, `ks_rcon_idx`=cnt, `ks_inverse`=0; wk ← `ks_next`; cnt++.
  - On the edge with cnt=10: K10 ← `ks_next`, go to READY.
  - Duration is exactly 10 cycles.
- READY, on data_valid & `enable` → RUN (acceptance edge A):
  - Latch mode ← `encrypt`.
  - Encrypt: state ← `inputData` ^ K0; wk ← ks_fwd(K0, rcon 1).
  - Decrypt: state ← `inputData` ^ K10; wk ← ks_inv(K10, rcon 10).
  - Clear `result_valid`; r ← 1.
- RUN, edges A+1..A+10:
  - `rnd_state`=state, `rnd_key`=wk, `rnd_inverse`=~mode, `rnd_final`=(r==10). state ← `rnd_out`.
  - If r<10, advance wk: encrypt uses ks_fwd with index r+1; decrypt uses ks_inv with index 10−r.
  - At A+10: `result` ← `rnd_out`, `result_valid` ← 1, go to READY.
  - `result_valid` is first high in the cycle after edge A+10 (latency 10 edges).
- Outside RUN, `rnd_*` and `ks_*` outputs are held at 0, except `ks_*` during KEYEXP.
- Pending data: data_valid while not READY, with `enable`=1, sets pend_d and captures `inputData` (one-deep).
  - A second data_valid overwrites the captured block (last wins).
  - Pending data is accepted on the first cycle in READY, using `encrypt` sampled at that cycle.
- Pending key: key_valid during RUN or KEYEXP sets pend_k and captures `keyWord`.
  - The current block or expansion completes with the old key.
  - Then KEYEXP restarts with the new key, before any pending data.
- Simultaneous key_valid and data_valid in READY: key is processed first; data becomes pending.
- data_valid with `enable`=0 is dropped; an in-flight block still completes.
- data_valid in IDLE with no key: pending (per rule above), served after the first KEYEXP.
- K0/K10 persist across blocks; they change only via KEYEXP.

Decomposition:
- Package aes_ctrl_pkg holds:
  - enum seq_state_t {IDLE, KEYEXP, READY, RUN};
  - localparams NUM_ROUNDS=10 and BLOCK_W=128.
- RCON lives in the key-schedule block, not here.
- No sub-module. The round function and key step are external combinational blocks. The bench instantiates the team's real ones.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, then after READY, data 00112233445566778899aabbccddeeff, `encrypt`=1 → `result` 69c4e0d86a7b0430d8cdb78070b4c55a, `result_valid` 10 edges after acceptance, `busy`=1 for exactly those 10 cycles.
- Decrypt C.1: same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, `encrypt`=0 → 00112233445566778899aabbccddeeff.
- Key expansion: key 2b7e151628aed2a6abf7158809cf4f3c → internal K10 d014f9a8c9ee2589e13f0cc8b6630ca6 after exactly 10 cycles. Then data 3243f6a8885a308d313198a2e0370734 encrypts to 3925841d02dc09fbdc118597196a0b32.
- Pending: second data_valid at A+3 → second block accepted on the edge after A+10; both results correct, in order.
- Key change mid-RUN to the C.1 key while processing a B-vector block → that block uses the old key (3925841d…); KEYEXP then runs; the next block uses the new key.
- HRESET asserted at A+5 → `result_valid`=0, `busy`=0, FSM IDLE the next cycle; key must be reloaded before further blocks.

Source files
------------

// File: rtl/aes_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, KEYEXP, READY, RUN} seq_state_t;

  localparam int NUM_ROUNDS = 10;
  localparam int BLOCK_W    = 128;
endpackage

// File: rtl/aes_round_sequencer.sv
// AES-128 round sequencer: owns state/key registers and steps the external
// round function and key-schedule step once per clock.
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             enable,
  input  logic             encrypt,
  input  logic             data_valid,
  input  logic [KEY_W-1:0] inputData,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] keyWord,
  output logic [KEY_W-1:0] rnd_state,
  output logic [KEY_W-1:0] rnd_key,
  output logic             rnd_final,
  output logic             rnd_inverse,
  input  logic [KEY_W-1:0] rnd_out,
  output logic [KEY_W-1:0] ks_key,
  output logic [3:0]       ks_rcon_idx,
  output logic             ks_inverse,
  input  logic [KEY_W-1:0] ks_next,
  output logic [KEY_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output seq_state_t       dbg_state
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  seq_state_t       st_q, st_d;
  logic [KEY_W-1:0] state_q, k0_q, k10_q, wk_q, result_q;
  logic [KEY_W-1:0] pend_data_q, pend_key_q;
  logic [3:0]       cnt_q;
  logic             mode_q, result_valid_q, pend_d_q, pend_k_q;

  logic             start_key, accept, data_req;
  logic [KEY_W-1:0] new_key, acc_data;

  // Handshake: data_valid/key_valid are one-cycle commit pulses with no
  // back-pressure; anything that cannot be taken immediately is parked in a
  // one-deep pending slot (newest wins). result_valid rises one edge after the
  // final round and drops on the edge that accepts the next block.
  always_comb begin
    start_key = 1'b0;
    accept    = 1'b0;
    st_d      = st_q;
    data_req  = (data_valid & enable) | pend_d_q;
    acc_data  = (data_valid & enable) ? inputData : pend_data_q;
    new_key   = key_valid ? keyWord : pend_key_q;
    case (st_q)
      IDLE, READY: begin
        if (key_valid | pend_k_q) begin
          start_key = 1'b1;
          st_d      = KEYEXP;
        end else if ((st_q == READY) && data_req) begin
          accept = 1'b1;
          st_d   = RUN;
        end
      end
      KEYEXP:  if (cnt_q == LAST) st_d = READY;
      RUN:     if (cnt_q == LAST) st_d = READY;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    rnd_state   = '0;
    rnd_key     = '0;
    rnd_final   = 1'b0;
    rnd_inverse = 1'b0;
    ks_key      = '0;
    ks_rcon_idx = '0;
    ks_inverse  = 1'b0;
    case (st_q)
      KEYEXP: begin
        ks_key      = wk_q;
        ks_rcon_idx = cnt_q;
      end
      RUN: begin
        rnd_state   = state_q;
        rnd_key     = wk_q;
        rnd_inverse = ~mode_q;
        rnd_final   = (cnt_q == LAST);
        if (cnt_q != LAST) begin
          ks_key      = wk_q;
          ks_rcon_idx = mode_q ? (cnt_q + 4'd1) : (LAST - cnt_q);
          ks_inverse  = ~mode_q;
        end
      end
      READY: begin
        // On acceptance the first round key is derived from K0 or K10.
        if (accept) begin
          ks_key      = encrypt ? k0_q : k10_q;
          ks_rcon_idx = encrypt ? 4'd1 : LAST;
          ks_inverse  = ~encrypt;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      st_q           <= IDLE;
      state_q        <= '0;
      k0_q           <= '0;
      k10_q          <= '0;
      wk_q           <= '0;
      result_q       <= '0;
      pend_data_q    <= '0;
      pend_key_q     <= '0;
      cnt_q          <= '0;
      mode_q         <= 1'b0;
      result_valid_q <= 1'b0;
      pend_d_q       <= 1'b0;
      pend_k_q       <= 1'b0;
    end else begin
      st_q <= st_d;

      if (start_key) begin
        k0_q     <= new_key;
        wk_q     <= new_key;
        cnt_q    <= 4'd1;
        pend_k_q <= 1'b0;
      end else if (key_valid) begin
        pend_k_q   <= 1'b1;
        pend_key_q <= keyWord;
      end

      if (accept) begin
        mode_q         <= encrypt;
        state_q        <= acc_data ^ (encrypt ? k0_q : k10_q);
        wk_q           <= ks_next;
        cnt_q          <= 4'd1;
        result_valid_q <= 1'b0;
        pend_d_q       <= 1'b0;
      end else if (data_valid & enable) begin
        pend_d_q    <= 1'b1;
        pend_data_q <= inputData;
      end

      if (st_q == KEYEXP) begin
        wk_q  <= ks_next;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == LAST) k10_q <= ks_next;
      end

      if (st_q == RUN) begin
        state_q <= rnd_out;
        if (cnt_q == LAST) begin
          result_q       <= rnd_out;
          result_valid_q <= 1'b1;
        end else begin
          wk_q  <= ks_next;
          cnt_q <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign busy         = (st_q == KEYEXP) | (st_q == RUN) | pend_d_q | pend_k_q;
  assign dbg_state    = st_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: supplies a behavioural AES round function and
// key step, applies a vector table and hand-written multi-cycle sequences.
module tb_aes_round_sequencer;
  import aes_ctrl_pkg::*;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K10_B  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         tb_HCLK = 1'b0;
  logic         HRESET, enable, encrypt, data_valid, key_valid;
  logic [127:0] inputData, keyWord;
  logic [127:0] rnd_state, rnd_key, rnd_out, ks_key, ks_next, result;
  logic         rnd_final, rnd_inverse, ks_inverse, result_valid, busy;
  logic [3:0]   ks_rcon_idx;
  seq_state_t   dbg_state;

  typedef struct {
    logic [127:0] key;
    logic [127:0] k10;
    logic [127:0] din;
    logic         enc;
    logic [127:0] dout;
  } vec_t;

  vec_t         vecs[5];
  logic [127:0] exp_q[$];
  logic [127:0] cur_key;
  int           n_chk, n_err;

  always #5 tb_HCLK = ~tb_HCLK;

  aes_round_sequencer dut (
    .HCLK(tb_HCLK), .HRESET(HRESET), .enable(enable), .encrypt(encrypt),
    .data_valid(data_valid), .inputData(inputData), .key_valid(key_valid),
    .keyWord(keyWord), .rnd_state(rnd_state), .rnd_key(rnd_key),
    .rnd_final(rnd_final), .rnd_inverse(rnd_inverse), .rnd_out(rnd_out),
    .ks_key(ks_key), .ks_rcon_idx(ks_rcon_idx), .ks_inverse(ks_inverse),
    .ks_next(ks_next), .result(result), .result_valid(result_valid),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01; p = a;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] b, int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] gb(logic [127:0] s, int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [7:0] rcon(logic [3:0] i);
    case (i)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] key_t(logic [31:0] w, logic [3:0] i);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox(r[31:24]) ^ rcon(i), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  function automatic logic [127:0] ks_fwd(logic [127:0] k, logic [3:0] i);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ key_t(k[31:0], i);
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] ks_inv(logic [127:0] k, logic [3:0] i);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0] ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ key_t(p3, i);
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [127:0] fwd_round(logic [127:0] s, logic [127:0] k, logic fin);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = sbox(gb(s, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4)));
    m = t;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
        m[127-8*(4*c)   -: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
        m[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
        m[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
        m[127-8*(4*c+3) -: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
    end
    return m ^ k;
  endfunction

  function automatic logic [127:0] inv_round(logic [127:0] s, logic [127:0] k, logic fin);
    logic [127:0] t, m;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++)
      t[127-8*i -: 8] = inv_sbox(gb(s, (i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)));
    t = t ^ k;
    m = t;
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
        m[127-8*(4*c)   -: 8] = gmul(a0, 8'he) ^ gmul(a1, 8'hb) ^ gmul(a2, 8'hd) ^ gmul(a3, 8'h9);
        m[127-8*(4*c+1) -: 8] = gmul(a0, 8'h9) ^ gmul(a1, 8'he) ^ gmul(a2, 8'hb) ^ gmul(a3, 8'hd);
        m[127-8*(4*c+2) -: 8] = gmul(a0, 8'hd) ^ gmul(a1, 8'h9) ^ gmul(a2, 8'he) ^ gmul(a3, 8'hb);
        m[127-8*(4*c+3) -: 8] = gmul(a0, 8'hb) ^ gmul(a1, 8'hd) ^ gmul(a2, 8'h9) ^ gmul(a3, 8'he);
      end
    end
    return m;
  endfunction

  always_comb rnd_out = rnd_inverse ? inv_round(rnd_state, rnd_key, rnd_final)
                                    : fwd_round(rnd_state, rnd_key, rnd_final);
  always_comb ks_next = ks_inverse ? ks_inv(ks_key, ks_rcon_idx) : ks_fwd(ks_key, ks_rcon_idx);

  // ---------------- checking / driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge tb_HCLK);
  endtask

  // Entered at the sample just after the edge that started KEYEXP.
  task automatic expect_keyexp(input logic [127:0] k10);
    int n;
    n = 0;
    while (dbg_state == KEYEXP && n < 30) begin
      n++;
      tick();
    end
    check_int("keyexp_cycles", n, 10);
    check("keyexp_done_state", 128'(dbg_state), 128'(READY));
    check("k10", dut.k10_q, k10);
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] k10);
    key_valid = 1'b1; keyWord = k;
    tick();
    key_valid = 1'b0;
    expect_keyexp(k10);
  endtask

  // Entered in READY; returns at the sample where result_valid rose.
  task automatic run_block(input logic [127:0] din, input logic enc, input logic [127:0] dout);
    int lat, busy_cnt;
    data_valid = 1'b1; inputData = din; encrypt = enc;
    tick();
    data_valid = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!result_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check_int("block_latency", lat, 10);
    check_int("block_busy_cycles", busy_cnt, 10);
    check("block_busy_after", 128'(busy), 128'(0));
    check("block_result", result, dout);
  endtask

  // Counts edges from the current sample until result_valid is seen.
  task automatic wait_result(input int exp_edges, input logic [127:0] dout);
    int n;
    for (n = 1; n <= 40; n++) begin
      tick();
      if (result_valid) break;
    end
    check_int("result_edges", n, exp_edges);
    check("result_value", result, dout);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    n_chk = 0; n_err = 0;
    HRESET = 1'b1; enable = 1'b1; encrypt = 1'b0;
    data_valid = 1'b0; key_valid = 1'b0; inputData = '0; keyWord = '0;

    vecs[0] = '{KEY_C1, K10_C1, PT_C1, 1'b1, CT_C1};
    vecs[1] = '{KEY_C1, K10_C1, CT_C1, 1'b0, PT_C1};
    vecs[2] = '{KEY_B,  K10_B,  PT_B,  1'b1, CT_B};
    vecs[3] = '{KEY_B,  K10_B,  CT_B,  1'b0, PT_B};
    vecs[4] = '{KEY_C1, K10_C1, PT_C1, 1'b1, CT_C1};

    repeat (3) tick();
    HRESET = 1'b0;
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    check("rst_result_valid", 128'(result_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_result", result, '0);
    check("rst_rnd_state", rnd_state, '0);
    check("rst_ks_key", ks_key, '0);
    check("rst_ks_rcon", 128'(ks_rcon_idx), 128'(0));

    // Table: reload the key only when it changes between entries.
    cur_key = '1;
    for (int i = 0; i < 5; i++) begin
      if (cur_key !== vecs[i].key) begin
        load_key(vecs[i].key, vecs[i].k10);
        cur_key = vecs[i].key;
      end
      run_block(vecs[i].din, vecs[i].enc, vecs[i].dout);
    end

    // Second block arrives at A+3 and is served right after the first.
    exp_q.push_back(CT_C1);
    exp_q.push_back(PT_C1);
    data_valid = 1'b1; inputData = PT_C1; encrypt = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (2) tick();
    data_valid = 1'b1; inputData = CT_C1; encrypt = 1'b0;
    tick();
    data_valid = 1'b0;
    lat = 3;
    while (!result_valid && lat < 20) begin tick(); lat++; end
    check_int("pend_first_latency", lat, 10);
    check("pend_first_result", result, exp_q.pop_front());
    check("pend_busy_between", 128'(busy), 128'(1));
    tick();
    check("pend_rv_cleared", 128'(result_valid), 128'(0));
    lat = 11;
    while (!result_valid && lat < 40) begin tick(); lat++; end
    check_int("pend_second_latency", lat, 21);
    check("pend_second_result", result, exp_q.pop_front());
    check_int("pend_queue_empty", exp_q.size(), 0);

    // Key change while a block is in flight.
    load_key(KEY_B, K10_B);
    data_valid = 1'b1; inputData = PT_B; encrypt = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (4) tick();
    key_valid = 1'b1; keyWord = KEY_C1;
    tick();
    key_valid = 1'b0;
    lat = 5;
    while (!result_valid && lat < 20) begin tick(); lat++; end
    check_int("keychg_latency", lat, 10);
    check("keychg_old_key_result", result, CT_B);
    check("keychg_busy_pending", 128'(busy), 128'(1));
    lat = 0;
    while (dbg_state != KEYEXP && lat < 5) begin tick(); lat++; end
    check_int("keychg_restart_delay", lat, 1);
    expect_keyexp(K10_C1);
    run_block(PT_C1, 1'b1, CT_C1);

    // Data with enable low is dropped.
    enable = 1'b0; data_valid = 1'b1; inputData = PT_B;
    tick();
    data_valid = 1'b0; enable = 1'b1;
    repeat (3) tick();
    check("drop_state", 128'(dbg_state), 128'(READY));
    check("drop_busy", 128'(busy), 128'(0));

    // Key and data together in READY: key first, data afterwards.
    key_valid = 1'b1; keyWord = KEY_C1;
    data_valid = 1'b1; inputData = CT_C1; encrypt = 1'b0;
    tick();
    key_valid = 1'b0; data_valid = 1'b0;
    check("simul_busy", 128'(busy), 128'(1));
    expect_keyexp(K10_C1);
    wait_result(11, PT_C1);

    // Reset in the middle of a block.
    data_valid = 1'b1; inputData = PT_C1; encrypt = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (4) tick();
    HRESET = 1'b1;
    tick();
    HRESET = 1'b0;
    check("midrst_state", 128'(dbg_state), 128'(IDLE));
    check("midrst_rv", 128'(result_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_result", result, '0);
    data_valid = 1'b1; inputData = PT_B; encrypt = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (12) tick();
    check("nokey_state", 128'(dbg_state), 128'(IDLE));
    check("nokey_busy", 128'(busy), 128'(1));
    check("nokey_rv", 128'(result_valid), 128'(0));
    load_key(KEY_B, K10_B);
    wait_result(11, CT_B);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
